// File: rtl/adder_err_pkg.sv
// Shared types, default widths and the saturating-add helpers for the
// approximate-adder error-evaluation engine.
package adder_err_pkg;

   // Campaign control states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Default widths: operand, sample counter, absolute-error accumulator
   localparam int OPW_D  = 6;
   localparam int CNTW_D = 16;
   localparam int ACCW_D = 32;

   // All-ones limit of a w-bit accumulator (w in 1..64), carried in 65 bits
   function automatic logic [64:0] sat_lim(input int unsigned w);
      return (65'd1 << w) - 65'd1;
   endfunction

   // Saturating add of two w-bit values held zero-extended in 64 bits;
   // the caller truncates the result back to w bits.
   function automatic logic [63:0] sat_add(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int unsigned w);
      logic [64:0] sum;
      logic [64:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = sat_lim(w);
      if (sum > lim) begin
         return lim[63:0];
      end else begin
         return sum[63:0];
      end
   endfunction

   // Companion of sat_add: high when the w-bit sum would exceed all-ones
   function automatic logic add_ovf(input logic [63:0] a,
                                    input logic [63:0] b,
                                    input int unsigned w);
      logic [64:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum > sat_lim(w));
   endfunction

endpackage

// File: rtl/adder_err_diff.sv
// Combinational front end: exact OPW+1-bit sum of the operands, absolute
// distance to the approximate sum and a mismatch flag.
module adder_err_diff
   import adder_err_pkg::*;
#(
   parameter int OPW = OPW_D
) (
   input  logic [OPW-1:0] op_a_i,
   input  logic [OPW-1:0] op_b_i,
   input  logic [OPW:0]   approx_sum_i,
   output logic [OPW:0]   abs_err_o,
   output logic           mismatch_o
);

   logic [OPW:0] exact_s;

   // Exact sum keeps the carry-out, so it can never truncate
   always_comb begin
      exact_s = {1'b0, op_a_i} + {1'b0, op_b_i};
   end

   // Absolute difference without a signed intermediate
   always_comb begin
      if (exact_s >= approx_sum_i) begin
         abs_err_o = exact_s - approx_sum_i;
      end else begin
         abs_err_o = approx_sum_i - exact_s;
      end
      mismatch_o = (exact_s != approx_sum_i);
   end

endmodule

// File: rtl/adder_err_eval.sv
// Streaming error-evaluation engine for approximate adders. Samples pass a
// 2-stage pipeline (difference capture, statistics update) at one per clock.
// Optional macro ADDER_ERR_EVAL_SQ_EN adds a saturating sum of squared error;
// without it sum_sq_err is tied to zero and no multiplier exists.
module adder_err_eval
   import adder_err_pkg::*;
#(
   parameter int OPW  = OPW_D,
   parameter int CNTW = CNTW_D,
   parameter int ACCW = ACCW_D
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNTW-1:0]   num_samples,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPW-1:0]    op_a,
   input  logic [OPW-1:0]    op_b,
   input  logic [OPW:0]      approx_sum,
   output logic              busy,
   output logic              done,
   output logic [CNTW-1:0]   sample_count,
   output logic [CNTW-1:0]   err_count,
   output logic [ACCW-1:0]   sum_abs_err,
   output logic [OPW:0]      max_abs_err,
   output logic              acc_ovf,
   output logic [2*ACCW-1:0] sum_sq_err
);

   localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
   localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
   localparam logic [ACCW-1:0] ACC_ZERO = {ACCW{1'b0}};
   localparam logic [OPW:0]    ERR_ZERO = {(OPW+1){1'b0}};

   state_e          state_q;
   logic [CNTW-1:0] num_q;
   logic [CNTW-1:0] accepted_q;
   logic [CNTW-1:0] accepted_d;
   logic [CNTW-1:0] sample_count_q;
   logic [CNTW-1:0] err_count_q;
   logic [ACCW-1:0] sum_abs_q;
   logic [ACCW-1:0] sum_abs_d;
   logic [OPW:0]    max_abs_q;
   logic [OPW:0]    max_abs_d;
   logic            acc_ovf_q;
   logic            busy_q;
   logic            done_q;
   logic            in_ready_q;

   logic            s1_valid_q;
   logic [OPW:0]    s1_abs_q;
   logic            s1_mis_q;

   logic            xfer_s;
   logic [OPW:0]    abs_err_s;
   logic            mismatch_s;
   logic            abs_sat_s;
   logic            sq_sat_s;

`ifdef ADDER_ERR_EVAL_SQ_EN
   localparam logic [2*ACCW-1:0] SQ_ZERO = {(2*ACCW){1'b0}};
   logic [2*ACCW-1:0] sum_sq_q;
   logic [2*ACCW-1:0] sum_sq_d;
   logic [2*OPW+1:0]  sq_s;
`endif

   assign xfer_s = in_valid && in_ready_q;

   adder_err_diff #(
      .OPW (OPW)
   ) u_diff (
      .op_a_i       (op_a),
      .op_b_i       (op_b),
      .approx_sum_i (approx_sum),
      .abs_err_o    (abs_err_s),
      .mismatch_o   (mismatch_s)
   );

   // Next values of the acceptance counter and the stage-2 accumulators
   always_comb begin
      if (xfer_s) begin
         accepted_d = accepted_q + CNT_ONE;
      end else begin
         accepted_d = accepted_q;
      end
      sum_abs_d = ACCW'(sat_add(64'(sum_abs_q), 64'(s1_abs_q), ACCW));
      abs_sat_s = add_ovf(64'(sum_abs_q), 64'(s1_abs_q), ACCW);
      if (s1_abs_q > max_abs_q) begin
         max_abs_d = s1_abs_q;
      end else begin
         max_abs_d = max_abs_q;
      end
   end

`ifdef ADDER_ERR_EVAL_SQ_EN
   // Squared error of the stage-1 sample and its saturating accumulation
   always_comb begin
      sq_s     = {{(OPW+1){1'b0}}, s1_abs_q} * {{(OPW+1){1'b0}}, s1_abs_q};
      sum_sq_d = (2*ACCW)'(sat_add(64'(sum_sq_q), 64'(sq_s), 2*ACCW));
      sq_sat_s = add_ovf(64'(sum_sq_q), 64'(sq_s), 2*ACCW);
   end
`else
   // No squared-error path: nothing can saturate there
   always_comb begin
      sq_sat_s = 1'b0;
   end
`endif

   // Campaign FSM, stage-1 capture and stage-2 statistics update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         num_q          <= CNT_ZERO;
         accepted_q     <= CNT_ZERO;
         sample_count_q <= CNT_ZERO;
         err_count_q    <= CNT_ZERO;
         sum_abs_q      <= ACC_ZERO;
         max_abs_q      <= ERR_ZERO;
         acc_ovf_q      <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         in_ready_q     <= 1'b0;
         s1_valid_q     <= 1'b0;
         s1_abs_q       <= ERR_ZERO;
         s1_mis_q       <= 1'b0;
`ifdef ADDER_ERR_EVAL_SQ_EN
         sum_sq_q       <= SQ_ZERO;
`endif
      end else begin
         s1_valid_q <= xfer_s;
         if (xfer_s) begin
            s1_abs_q <= abs_err_s;
            s1_mis_q <= mismatch_s;
         end
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  num_q          <= num_samples;
                  accepted_q     <= CNT_ZERO;
                  sample_count_q <= CNT_ZERO;
                  err_count_q    <= CNT_ZERO;
                  sum_abs_q      <= ACC_ZERO;
                  max_abs_q      <= ERR_ZERO;
                  acc_ovf_q      <= 1'b0;
`ifdef ADDER_ERR_EVAL_SQ_EN
                  sum_sq_q       <= SQ_ZERO;
`endif
                  // An empty campaign completes at once and never runs
                  if (num_samples == CNT_ZERO) begin
                     state_q    <= ST_DONE;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                     in_ready_q <= 1'b0;
                  end else begin
                     state_q    <= ST_RUN;
                     busy_q     <= 1'b1;
                     done_q     <= 1'b0;
                     in_ready_q <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               accepted_q <= accepted_d;
               if (s1_valid_q) begin
                  sample_count_q <= sample_count_q + CNT_ONE;
                  if (s1_mis_q) begin
                     err_count_q <= err_count_q + CNT_ONE;
                  end
                  sum_abs_q <= sum_abs_d;
                  max_abs_q <= max_abs_d;
                  acc_ovf_q <= acc_ovf_q | abs_sat_s | sq_sat_s;
`ifdef ADDER_ERR_EVAL_SQ_EN
                  sum_sq_q  <= sum_sq_d;
`endif
               end
               // All samples retired once the stage-2 count reaches the target
               if (sample_count_q == num_q) begin
                  state_q    <= ST_DONE;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  in_ready_q <= 1'b0;
               end else begin
                  in_ready_q <= (accepted_d < num_q);
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready     = in_ready_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign sample_count = sample_count_q;
   assign err_count    = err_count_q;
   assign sum_abs_err  = sum_abs_q;
   assign max_abs_err  = max_abs_q;
   assign acc_ovf      = acc_ovf_q;
`ifdef ADDER_ERR_EVAL_SQ_EN
   assign sum_sq_err   = sum_sq_q;
`else
   assign sum_sq_err   = {(2*ACCW){1'b0}};
`endif

endmodule

// File: tb/tb_adder_err_eval.sv
// Scoreboard bench for adder_err_eval: stimulus pushes the expected campaign
// result when it issues a campaign; a negedge monitor pops and compares when
// done rises, and checks that every output is zero while reset is held.
module tb_adder_err_eval;

`ifdef ADDER_ERR_EVAL_SQ_EN
   localparam bit SQ = 1'b1;
`else
   localparam bit SQ = 1'b0;
`endif

   typedef struct {
      logic [63:0] cnt;
      logic [63:0] err;
      logic [63:0] sum;
      logic [63:0] mx;
      logic [63:0] ovf;
      logic [63:0] sq;
      logic [63:0] xf;
      logic [63:0] bsy;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // DUT 0: default widths
   logic        start0 = 1'b0, in_valid0 = 1'b0;
   logic [15:0] num0 = 16'd0;
   logic [5:0]  a0 = 6'd0, b0 = 6'd0;
   logic [6:0]  s0 = 7'd0;
   logic        in_ready0, busy0, done0, ovf0;
   logic [15:0] cnt0, err0;
   logic [31:0] sum0;
   logic [6:0]  max0;
   logic [63:0] sq0;

   // DUT 8: 8-bit accumulator for saturation
   logic        start8 = 1'b0, in_valid8 = 1'b0;
   logic [15:0] num8 = 16'd0;
   logic [5:0]  a8 = 6'd0, b8 = 6'd0;
   logic [6:0]  s8 = 7'd0;
   logic        in_ready8, busy8, done8, ovf8;
   logic [15:0] cnt8, err8;
   logic [7:0]  sum8;
   logic [6:0]  max8;
   logic [15:0] sq8;

   exp_t q0[$];
   exp_t q8[$];
   int n_pass = 0;
   int n_tot  = 0;

   int  xf[2];
   int  lat[2];
   logic bs[2];
   logic dp[2];
   logic rst_seen = 1'b0;

   always #5 clk = ~clk;

   adder_err_eval #(.OPW(6), .CNTW(16), .ACCW(32)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .num_samples(num0),
      .in_valid(in_valid0), .in_ready(in_ready0), .op_a(a0), .op_b(b0),
      .approx_sum(s0), .busy(busy0), .done(done0), .sample_count(cnt0),
      .err_count(err0), .sum_abs_err(sum0), .max_abs_err(max0),
      .acc_ovf(ovf0), .sum_sq_err(sq0)
   );

   adder_err_eval #(.OPW(6), .CNTW(16), .ACCW(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .num_samples(num8),
      .in_valid(in_valid8), .in_ready(in_ready8), .op_a(a8), .op_b(b8),
      .approx_sum(s8), .busy(busy8), .done(done8), .sample_count(cnt8),
      .err_count(err8), .sum_abs_err(sum8), .max_abs_err(max8),
      .acc_ovf(ovf8), .sum_sq_err(sq8)
   );

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   task automatic mon(input int d, input logic st, input logic iv, input logic ir,
                      input logic bsy, input logic dn, input logic [63:0] c,
                      input logic [63:0] e, input logic [63:0] s, input logic [63:0] m,
                      input logic [63:0] o, input logic [63:0] q);
      exp_t r;
      string p;
      p = (d == 0) ? "dut0" : "dut8";
      if (iv && ir) xf[d]++;
      if (bsy) bs[d] = 1'b1;
      if (st) lat[d] = 0; else lat[d]++;
      if (dn && !dp[d]) begin
         chk({p, " expectations queued at done"}, (d == 0) ? q0.size() : q8.size(), 1);
         if ((d == 0 && q0.size() > 0) || (d == 1 && q8.size() > 0)) begin
            if (d == 0) r = q0.pop_front(); else r = q8.pop_front();
            chk({p, " sample_count"}, c, r.cnt);
            chk({p, " err_count"}, e, r.err);
            chk({p, " sum_abs_err"}, s, r.sum);
            chk({p, " max_abs_err"}, m, r.mx);
            chk({p, " acc_ovf"}, o, r.ovf);
            chk({p, " sum_sq_err"}, q, r.sq);
            chk({p, " transfers"}, 64'(xf[d]), r.xf);
            chk({p, " busy seen"}, 64'(bs[d]), r.bsy);
            chk({p, " busy at done"}, 64'(bsy), 64'd0);
            if (r.lat >= 0) chk({p, " start-to-done cycles"}, 64'(lat[d]), 64'(r.lat));
         end
         xf[d] = 0;
         bs[d] = 1'b0;
      end
      dp[d] = dn;
   endtask

   // Monitor: reset-state check and scoreboard comparison at done
   always @(negedge clk) begin
      if (!rst_n) begin
         if (!rst_seen) begin
            chk("reset in_ready", 64'(in_ready0), 64'd0);
            chk("reset busy", 64'(busy0), 64'd0);
            chk("reset done", 64'(done0), 64'd0);
            chk("reset sample_count", 64'(cnt0), 64'd0);
            chk("reset err_count", 64'(err0), 64'd0);
            chk("reset sum_abs_err", 64'(sum0), 64'd0);
            chk("reset max_abs_err", 64'(max0), 64'd0);
            chk("reset acc_ovf", 64'(ovf0), 64'd0);
            chk("reset sum_sq_err", sq0, 64'd0);
            chk("reset dut8 outputs", 64'({in_ready8, busy8, done8, ovf8, cnt8, err8, sum8, max8}) | 64'(sq8), 64'd0);
         end
         rst_seen = 1'b1;
         for (int k = 0; k < 2; k++) begin
            xf[k] = 0; bs[k] = 1'b0; dp[k] = 1'b0; lat[k] = 0;
         end
      end else begin
         rst_seen = 1'b0;
         mon(0, start0, in_valid0, in_ready0, busy0, done0, 64'(cnt0), 64'(err0),
             64'(sum0), 64'(max0), 64'(ovf0), sq0);
         mon(1, start8, in_valid8, in_ready8, busy8, done8, 64'(cnt8), 64'(err8),
             64'(sum8), 64'(max8), 64'(ovf8), 64'(sq8));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int d, input int c, input int e, input int s, input int m,
                       input int o, input int q, input int x, input int b, input int l);
      exp_t r;
      r.cnt = 64'(c); r.err = 64'(e); r.sum = 64'(s); r.mx = 64'(m);
      r.ovf = 64'(o); r.sq = SQ ? 64'(q) : 64'd0; r.xf = 64'(x); r.bsy = 64'(b); r.lat = l;
      if (d == 0) q0.push_back(r); else q8.push_back(r);
   endtask

   task automatic do_start(input int d, input int n);
      tick();
      if (d == 0) begin start0 = 1'b1; num0 = 16'(n); end
      else begin start8 = 1'b1; num8 = 16'(n); end
      tick();
      start0 = 1'b0;
      start8 = 1'b0;
   endtask

   task automatic send(input int d, input int a, input int b, input int s);
      int g = 0;
      if (d == 0) begin in_valid0 = 1'b1; a0 = 6'(a); b0 = 6'(b); s0 = 7'(s); end
      else begin in_valid8 = 1'b1; a8 = 6'(a); b8 = 6'(b); s8 = 7'(s); end
      while (!((d == 0) ? in_ready0 : in_ready8) && g < 50) begin
         tick();
         g++;
      end
      if (g >= 50) begin
         $display("FAIL send timeout dut%0d: in_ready low for %0d cycles, required high", d, g);
         $fatal(1);
      end
      tick();
      in_valid0 = 1'b0;
      in_valid8 = 1'b0;
   endtask

   task automatic wait_done(input int d);
      int g = 0;
      while (!((d == 0) ? done0 : done8) && g < 100) begin
         tick();
         g++;
      end
      if (g >= 100) begin
         $display("FAIL done timeout dut%0d: done low after %0d cycles, required high", d, g);
         $fatal(1);
      end
      tick();
   endtask

   task automatic pulse_reset();
      tick();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (3) tick();
      rst_n = 1'b1;

      // 1: exact campaign
      push(0, 3, 0, 0, 0, 0, 0, 3, 1, -1);
      do_start(0, 3);
      send(0, 5, 3, 8);
      send(0, 63, 63, 126);
      send(0, 0, 0, 0);
      wait_done(0);

      // 2: errors 64, 1 and 2 -> sum 67, squares 4096 + 1 + 4
      push(0, 3, 3, 67, 64, 0, 4101, 3, 1, -1);
      do_start(0, 3);
      send(0, 63, 63, 62);
      send(0, 10, 20, 31);
      send(0, 1, 1, 0);
      wait_done(0);

      // 3: in_valid held 5 cycles with 2 samples wanted; start during RUN ignored
      push(0, 2, 2, 2, 1, 0, 2, 2, 1, -1);
      do_start(0, 2);
      in_valid0 = 1'b1; a0 = 6'd7; b0 = 6'd9; s0 = 7'd17;
      for (int i = 0; i < 5; i++) begin
         tick();
         start0 = (i == 1);
         if (i == 1) num0 = 16'd9;
      end
      start0 = 1'b0;
      in_valid0 = 1'b0;
      wait_done(0);

      // 6: reset after 1 of 4 samples, then a clean campaign
      do_start(0, 4);
      send(0, 9, 9, 0);
      pulse_reset();
      push(0, 2, 1, 1, 1, 0, 1, 2, 1, -1);
      do_start(0, 2);
      send(0, 2, 2, 4);
      send(0, 3, 4, 6);
      wait_done(0);

      // 4: empty campaign from IDLE
      pulse_reset();
      push(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      do_start(0, 0);
      wait_done(0);

      // 5: 8-bit accumulator saturates after four errors of 64; new start clears
      push(1, 5, 5, 255, 64, 1, 20480, 5, 1, -1);
      do_start(1, 5);
      for (int i = 0; i < 5; i++) send(1, 0, 0, 64);
      wait_done(1);
      push(1, 1, 0, 0, 0, 0, 0, 1, 1, -1);
      do_start(1, 1);
      send(1, 5, 3, 8);
      wait_done(1);

      if (q0.size() != 0 || q8.size() != 0) begin
         $display("FAIL scoreboard drain: %0d/%0d expectations left, required 0/0", q0.size(), q8.size());
         $fatal(1);
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
